uart_tx_fsm: RTL and testbench
==============================

# uart_tx_fsm

Frame-level UART transmitter, the transmit-side counterpart of the team's receive FSM. Serialises one 8-bit byte per frame as start bit, 8 data bits LSB first, optional parity bit and 1 or 2 stop bits, advancing one bit per pulse of an externally generated bit-rate clock enable. A one-entry holding register lets the host queue the next byte while a frame is on the line, so consecutive frames go out back-to-back with no idle gap. Sits between the host-side byte interface and the TXD output pad register.

## Interface
- PARITY_EN, 1: 1 = parity bit present after data bits; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity, parity bit = ^data; 1 = odd parity, parity bit = ~^data. Ignored when PARITY_EN = 0.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- TX_CE  in  1  bit-rate enable; one-cycle pulse per bit period.
- TX_DATA  in  8  byte to send; sampled only on accept.
- TX_DATA_EN  in  1  write strobe; accept occurs when TX_DATA_EN = 1 and TX_RDY = 1.
- TX_RDY  out  1  holding register empty; 1 = a byte can be accepted.
- TX_BUSY  out  1  a frame is in progress on the line, from the start-bit edge to the end of the last stop bit.
- TX_DONE  out  1  one-cycle pulse at the end of each frame's last stop bit.
- TXD  out  1  serial line, registered, idle high.

## Operation
- Reset values: TXD = 1, TX_RDY = 1, TX_BUSY = 0, TX_DONE = 0. Holding register, shift register and counters are cleared; the state is IDLE.
- Accept: on a cycle with TX_DATA_EN = 1 and TX_RDY = 1, TX_DATA is loaded into the holding register and TX_RDY = 0 from the next cycle. TX_DATA_EN while TX_RDY = 0 is ignored; there is no error flag.
- States:
  - IDLE: TXD = 1. On a TX_CE with the holding register full, move the byte to the shift register, set TX_RDY = 1, drive TXD = 0 and go to START.
  - START: on TX_CE, drive data bit 0 and go to DATA.
  - DATA: on each TX_CE, shift right and drive the next bit; a 3-bit counter counts 0..7. On the TX_CE that ends bit 7, go to PARITY if PARITY_EN = 1, otherwise go to STOP with TXD = 1.
  - PARITY: the parity value is computed from the byte at load time. On TX_CE, go to STOP with TXD = 1.
  - STOP: a stop counter counts STOP_BITS periods. On the TX_CE ending the last stop bit, pulse TX_DONE. If the holding register is full, perform the IDLE load action in that same cycle (TXD = 0, go to START); otherwise go to IDLE.
- TX_BUSY = 1 in START, DATA, PARITY and STOP; 0 in IDLE.

## Timing
- Every TXD transition is registered and coincides with the clock edge that samples TX_CE = 1. Each bit lasts exactly one TX_CE period.
- Frame length is 1 + 8 + PARITY_EN + STOP_BITS TX_CE periods.
- Start latency: the first TX_CE strictly after the accept cycle starts the start bit. An accept in the same cycle as TX_CE does not use that TX_CE.
- Back-to-back: if the next byte is accepted before the last stop bit ends, the next start bit follows the stop bit with zero idle periods.
- TX_RDY returns to 1 in the cycle the holding register is transferred to the shift register, so the host can queue byte N+1 while byte N is on the line.
- TX_CE = 0 freezes all line state; only the accept path stays active.
- Reset asserted mid-frame: TXD goes to 1 immediately (asynchronously), the frame and any queued byte are discarded, and no TX_DONE is issued.

## Structure
- The shared include uart_defs.vh holds the state encodings, the data width (8) and the parity-mode constants, common with the receiver.
- Parity, the shift register and the holding register are inline; no sub-module is needed.

## Test plan
- TX_CE every 16 clocks, PARITY_EN = 1, PARITY_ODD = 0, STOP_BITS = 1; send 0xA5 -> TXD sequence 0,1,0,1,0,0,1,0,1,0,1; each bit 16 clocks; one TX_DONE pulse at the end of the frame; TX_BUSY high for 176 clocks.
- Same byte with PARITY_ODD = 1 -> parity bit 1. With PARITY_EN = 0 and STOP_BITS = 2 -> 0,1,0,1,0,0,1,0,1,1,1, frame length 11 periods.
- Queue 0x00 then 0xFF while the first frame is active -> second start bit immediately after the first stop bit; two TX_DONE pulses exactly 11 periods apart; TX_RDY low only while a byte is queued.
- TX_DATA_EN asserted while TX_RDY = 0 with byte 0x3C -> byte ignored; the transmitted bytes match only the accepted ones.
- Accept in the same cycle as TX_CE -> start bit begins at the following TX_CE, not the coincident one.
- Assert RST_N = 0 during data bit 4 -> TXD = 1 immediately; after release TX_RDY = 1, TX_BUSY = 0, no TX_DONE, and the next byte is sent correctly.

Source files
------------

// File: rtl/uart_tx_fsm_pkg.sv
// Shared constants for the UART transmit FSM: state encodings,
// data width, parity modes and the parity helper.
package uart_tx_fsm_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic calc_par(
        input logic [DATA_W-1:0] d,
        input logic              odd
    );
        return (odd == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Host-side byte interface of the UART transmitter.
// master: host (drives tx_data/tx_data_en); slave: transmitter (drives tx_rdy).
interface uart_tx_fsm_if;
    import uart_tx_fsm_pkg::*;

    logic [DATA_W-1:0] tx_data;
    logic              tx_data_en;
    logic              tx_rdy;

    modport master (output tx_data, output tx_data_en, input tx_rdy);
    modport slave  (input tx_data, input tx_data_en, output tx_rdy);

endinterface

// File: rtl/uart_tx_fsm.sv
// Frame-level UART transmitter with one-entry holding register.
// Ports: i_clk, i_rst_n (async low), i_tx_ce (bit-rate enable),
//   bus (host byte handshake), o_tx_busy, o_tx_done, o_txd (idle high).
module uart_tx_fsm
    import uart_tx_fsm_pkg::*;
#(
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_tx_ce,
    uart_tx_fsm_if.slave       bus,
    output logic               o_tx_busy,
    output logic               o_tx_done,
    output logic               o_txd
);

    localparam logic LAST_STOP = (STOP_BITS == 2);

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic [2:0]        r_bit_cnt;
    logic              r_stop_cnt;
    logic              r_txd;
    logic              r_done;

    logic w_accept;
    logic w_last_stop;
    logic w_load;

    assign w_accept    = bus.tx_data_en & ~r_hold_full;
    assign w_last_stop = (r_state == ST_STOP) & (r_stop_cnt == LAST_STOP);
    // A queued byte starts either from idle or straight out of the last
    // stop bit, which is what gives zero-gap back-to-back frames.
    assign w_load      = i_tx_ce & r_hold_full
                       & ((r_state == ST_IDLE) | w_last_stop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_txd       <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_load) begin
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold_full <= 1'b1;
                r_hold      <= bus.tx_data;
            end

            if (i_tx_ce) begin
                case (r_state)
                    ST_START: begin
                        r_txd     <= r_shift[0];
                        r_bit_cnt <= '0;
                        r_state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (r_bit_cnt == 3'd7) begin
                            r_stop_cnt <= 1'b0;
                            if (PARITY_EN) begin
                                r_txd   <= r_par;
                                r_state <= ST_PARITY;
                            end else begin
                                r_txd   <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_txd     <= r_shift[1];
                            r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        r_txd      <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (w_last_stop) begin
                            r_done <= 1'b1;
                            if (!r_hold_full) begin
                                r_txd   <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (w_load) begin
                r_shift <= r_hold;
                r_par   <= calc_par(r_hold, PARITY_ODD);
                r_txd   <= 1'b0;
                r_state <= ST_START;
            end
        end
    end

    assign bus.tx_rdy = ~r_hold_full;
    assign o_tx_busy  = (r_state != ST_IDLE);
    assign o_tx_done  = r_done;
    assign o_txd      = r_txd;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench: three transmitter configurations driven in parallel,
// checked every cycle against a frame-queue model plus literal expectations.
module tb_uart_tx_fsm;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       ce    = 1'b0;
    logic       en    = 1'b0;
    logic [7:0] data  = 8'h00;

    always #5 clk = ~clk;

    wire [2:0] busy, done, txd, rdy;

    uart_tx_fsm_if if0 ();
    uart_tx_fsm_if if1 ();
    uart_tx_fsm_if if2 ();

    assign if0.tx_data = data;
    assign if1.tx_data = data;
    assign if2.tx_data = data;
    assign if0.tx_data_en = en;
    assign if1.tx_data_en = en;
    assign if2.tx_data_en = en;
    assign rdy[0] = if0.tx_rdy;
    assign rdy[1] = if1.tx_rdy;
    assign rdy[2] = if2.tx_rdy;

    uart_tx_fsm #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_ce(ce), .bus(if0),
        .o_tx_busy(busy[0]), .o_tx_done(done[0]), .o_txd(txd[0]));
    uart_tx_fsm #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_ce(ce), .bus(if1),
        .o_tx_busy(busy[1]), .o_tx_done(done[1]), .o_txd(txd[1]));
    uart_tx_fsm #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_ce(ce), .bus(if2),
        .o_tx_busy(busy[2]), .o_tx_done(done[2]), .o_txd(txd[2]));

    localparam int PE[3] = '{1, 1, 0};
    localparam int PO[3] = '{0, 1, 0};
    localparam int SB[3] = '{1, 1, 2};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: a frame is a list of line levels; each TX_CE plays the next one.
    bit          m_hv[3]   = '{0, 0, 0};
    logic [7:0]  m_h[3];
    logic [15:0] m_fr[3];
    int          m_left[3] = '{0, 0, 0};
    bit          m_busy[3] = '{0, 0, 0};
    bit          m_txd[3]  = '{1, 1, 1};
    bit          m_done[3] = '{0, 0, 0};

    function automatic logic [15:0] mk_frame(input logic [7:0] d, input int i,
                                             output int n);
        logic [15:0] f;
        int ones;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        ones   = 0;
        for (int b = 0; b < 8; b++) ones += int'(d[b]);
        n = 9;
        if (PE[i] == 1) begin
            f[9] = (PO[i] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
            n = 10;
        end
        n += SB[i];
        return f;
    endfunction

    task automatic model_step();
        bit rdy_old;
        int n;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_hv[i] = 0; m_busy[i] = 0; m_txd[i] = 1;
                m_done[i] = 0; m_left[i] = 0;
                continue;
            end
            m_done[i] = 0;
            rdy_old = !m_hv[i];
            if (ce) begin
                if (m_busy[i] && m_left[i] > 0) begin
                    m_txd[i] = m_fr[i][0];
                    m_fr[i] = m_fr[i] >> 1;
                    m_left[i]--;
                end else begin
                    if (m_busy[i]) m_done[i] = 1;
                    if (m_hv[i]) begin
                        m_fr[i] = mk_frame(m_h[i], i, n);
                        m_txd[i] = m_fr[i][0];
                        m_fr[i] = m_fr[i] >> 1;
                        m_left[i] = n - 1;
                        m_busy[i] = 1;
                        m_hv[i] = 0;
                    end else begin
                        m_busy[i] = 0;
                        m_txd[i] = 1;
                    end
                end
            end
            if (en && rdy_old) begin
                m_hv[i] = 1;
                m_h[i] = data;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("txd%0d", i), 16'(txd[i]), 16'(m_txd[i]));
            chk($sformatf("rdy%0d", i), 16'(rdy[i]), 16'(!m_hv[i]));
            chk($sformatf("busy%0d", i), 16'(busy[i]), 16'(m_busy[i]));
            chk($sformatf("done%0d", i), 16'(done[i]), 16'(m_done[i]));
        end
    end

    int ce_cnt = 0;
    initial forever begin
        @(negedge clk);
        #1;
        ce_cnt = (ce_cnt == 15) ? 0 : ce_cnt + 1;
        ce = (ce_cnt == 15);
    end

    int cyc = 0;
    int busy_cnt = 0;
    int done_cnt[3] = '{0, 0, 0};
    int done_t[$];
    initial forever begin
        @(negedge clk);
        cyc++;
        if (busy[0] === 1'b1) busy_cnt++;
        for (int i = 0; i < 3; i++)
            if (done[i] === 1'b1) done_cnt[i]++;
        if (done[0] === 1'b1) done_t.push_back(cyc);
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        while (rdy[0] !== 1'b1 && k < 400) begin tick(); k++; end
        if (k >= 400) chk("send_timeout", 16'd0, 16'd1);
        en = 1'b1;
        data = b;
        tick();
        en = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy !== 3'b000 || rdy !== 3'b111) && k < 1000) begin
            tick(); k++;
        end
        if (k >= 1000) chk("idle_timeout", 16'd0, 16'd1);
    endtask

    logic [10:0] seq[3];
    task automatic capture();
        int k = 0;
        while (busy[0] !== 1'b1 && k < 100) begin tick(); k++; end
        if (k >= 100) chk("start_timeout", 16'd0, 16'd1);
        for (int b = 0; b < 11; b++) begin
            for (int i = 0; i < 3; i++) seq[i][b] = txd[i];
            repeat (16) tick();
        end
    endtask

    function automatic void clear_counts();
        busy_cnt = 0;
        done_t.delete();
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;
    endfunction

    initial begin
        int lat;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_txd", 16'(txd), 16'b111);
        chk("rst_rdy", 16'(rdy), 16'b111);
        chk("rst_busy", 16'(busy), 16'b000);
        chk("rst_done", 16'(done), 16'b000);
        rst_n = 1'b1;
        repeat (4) tick();

        clear_counts();
        send(8'hA5);
        capture();
        wait_idle();
        chk("a5_even", 16'(seq[0]), 16'(11'b10101001010));
        chk("a5_odd", 16'(seq[1]), 16'(11'b11101001010));
        chk("a5_nopar_2stop", 16'(seq[2]), 16'(11'b11101001010));
        chk("a5_busy_clks", 16'(busy_cnt), 16'd176);
        for (int i = 0; i < 3; i++)
            chk($sformatf("a5_done%0d", i), 16'(done_cnt[i]), 16'd1);

        clear_counts();
        send(8'h00);
        repeat (20) tick();
        send(8'hFF);
        chk("queued_rdy_low", 16'(rdy[0]), 16'd0);
        en = 1'b1;
        data = 8'h3C;
        tick();
        en = 1'b0;
        wait_idle();
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_done%0d", i), 16'(done_cnt[i]), 16'd2);
        if (done_t.size() == 2)
            chk("b2b_spacing", 16'(done_t[1] - done_t[0]), 16'd176);
        else
            chk("b2b_pulses", 16'(done_t.size()), 16'd2);
        chk("b2b_busy_clks", 16'(busy_cnt), 16'd352);

        lat = 0;
        while (ce !== 1'b1 && lat < 40) begin tick(); lat++; end
        en = 1'b1;
        data = 8'h81;
        tick();
        en = 1'b0;
        chk("coincident_no_start", 16'(busy[0]), 16'd0);
        lat = 1;
        while (busy[0] !== 1'b1 && lat < 40) begin tick(); lat++; end
        chk("coincident_latency", 16'(lat), 16'd17);
        wait_idle();

        clear_counts();
        send(8'h5A);
        lat = 0;
        while (busy[0] !== 1'b1 && lat < 100) begin tick(); lat++; end
        send(8'h99);
        repeat (87) tick();
        chk("mid_queued", 16'(rdy[0]), 16'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", 16'(txd), 16'b111);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_rdy", 16'(rdy), 16'b111);
        chk("post_rst_busy", 16'(busy), 16'b000);
        chk("post_rst_no_done", 16'(done_cnt[0] + done_cnt[1] + done_cnt[2]),
            16'd0);

        clear_counts();
        send(8'hC3);
        capture();
        wait_idle();
        chk("c3_even", 16'(seq[0]), 16'(11'b10110000110));
        chk("c3_odd", 16'(seq[1]), 16'(11'b11110000110));
        chk("c3_nopar_2stop", 16'(seq[2]), 16'(11'b11110000110));
        for (int i = 0; i < 3; i++)
            chk($sformatf("c3_done%0d", i), 16'(done_cnt[i]), 16'd1);

        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
